dmem_host_port: RTL

Data-memory responder for the PCPU data bus with a second, host-side bulk access engine. It holds the 256×16 data RAM that answers the CPU's `d_addr`/`d_we`/`d_dataout`/`d_datain` accesses. It also lets an external host dump or fill address ranges through valid/ready handshakes, replacing testbench-only memory dumps with synthesizable hardware. While an engine operation runs, the block holds the CPU off.

---
 rtl/dmem_host_port_if.sv | 44 ++++
 rtl/dmem_host_port.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/dmem_host_port_if.sv
// ============================================================================
// Module   : dmem_host_port_if
// Purpose  : CPU data-bus and host command/response signals for dmem_host_port.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface dmem_host_port_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] address;
  logic              we;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] q;
  logic              cpu_idle;
  logic              cpu_hold;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;
  logic [DATA_W-1:0] cmd_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic [ADDR_W-1:0] resp_addr;
  logic              done;
  logic              err;

  modport slave (
    input  address, we, data, cpu_idle, cmd_valid, cmd_op, cmd_addr, cmd_len,
           cmd_wdata, resp_ready,
    output q, cpu_hold, cmd_ready, resp_valid, resp_data, resp_addr, done, err
  );

  modport master (
    output address, we, data, cpu_idle, cmd_valid, cmd_op, cmd_addr, cmd_len,
           cmd_wdata, resp_ready,
    input  q, cpu_hold, cmd_ready, resp_valid, resp_data, resp_addr, done, err
  );
endinterface

`default_nettype wire

// File: rtl/dmem_host_port.sv
// ============================================================================
// Module   : dmem_host_port
// Purpose  : CPU data RAM with a host-driven dump/fill engine that holds the CPU.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_host_port #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  wire logic       clock,
  input  wire logic       reset,
  dmem_host_port_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_IDLE = 2'd1;
  localparam logic [1:0] ST_RUN       = 2'd2;

  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_CNT  = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] ram [DEPTH];

  logic [1:0]        state_q, state_d;
  logic              op_q, op_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              own;
  logic              hs;
  logic              last;
  logic [ADDR_W-1:0] ptr_inc;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

  always_comb begin
    own       = (state_q == ST_RUN) && bus.cpu_idle;
    hs        = own && !op_q && rvalid_q && bus.resp_ready;
    last      = (cnt_q == ONE_CNT);
    ptr_inc   = ptr_q + 1'b1;

    state_d   = state_q;
    op_d      = op_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    wdata_d   = wdata_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    raddr_d   = raddr_q;
    done_d    = 1'b0;
    err_d     = err_q | (own & bus.we);

    // CPU writes go through unless the engine owns the RAM this cycle.
    ram_we    = bus.we & ~own;
    ram_waddr = bus.address;
    ram_wdata = bus.data;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          op_d    = bus.cmd_op;
          ptr_d   = bus.cmd_addr;
          wdata_d = bus.cmd_wdata;
          cnt_d   = (bus.cmd_len == '0) ? FULL_CNT : {1'b0, bus.cmd_len};
          state_d = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (bus.cpu_idle) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (own) begin
          if (op_q) begin
            ram_we    = 1'b1;
            ram_waddr = ptr_q;
            ram_wdata = wdata_q;
            ptr_d     = ptr_inc;
            cnt_d     = cnt_q - 1'b1;
            if (last) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else if (hs) begin
            ptr_d = ptr_inc;
            cnt_d = cnt_q - 1'b1;
            if (last) begin
              state_d  = ST_IDLE;
              done_d   = 1'b1;
              rvalid_d = 1'b0;
            end else begin
              // Reload in the handshake cycle for one beat per clock.
              rvalid_d = 1'b1;
              rdata_d  = ram[ptr_inc];
              raddr_d  = ptr_inc;
            end
          end else if (!rvalid_q) begin
            rvalid_d = 1'b1;
            rdata_d  = ram[ptr_q];
            raddr_d  = ptr_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      op_q     <= 1'b0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      wdata_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      raddr_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      wdata_q  <= wdata_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      raddr_q  <= raddr_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Array contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
  end

  assign bus.q          = ram[bus.address];
  assign bus.cmd_ready  = reset && (state_q == ST_IDLE);
  assign bus.cpu_hold   = (state_q == ST_WAIT_IDLE) || (state_q == ST_RUN);
  assign bus.resp_valid = rvalid_q;
  assign bus.resp_data  = rdata_q;
  assign bus.resp_addr  = raddr_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
endmodule

`default_nettype wire
